// File: rtl/aes_core_sched.sv
// Two-requester round-robin sequencer for the shared AES core: caches the last expanded key,
// issues Krdy/Drdy strobes and returns results to the owner; a watchdog aborts a hung core.
module aes_core_sched #(
   parameter int TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         RST,
   input  logic         enable,
   input  logic         key_flush,
   input  logic [1:0]   rq_vld,
   input  logic [127:0] rq_key0,
   input  logic [127:0] rq_key1,
   input  logic [127:0] rq_din0,
   input  logic [127:0] rq_din1,
   input  logic [1:0]   rq_encdec,
   output logic [1:0]   rq_ack,
   output logic [1:0]   rsp_vld,
   output logic [127:0] rsp_data,
   output logic         rsp_err,
   output logic [127:0] Kin,
   output logic [127:0] Din,
   output logic         Krdy,
   output logic         Drdy,
   output logic         EncDec,
   input  logic         BSY,
   input  logic         Kvld,
   input  logic         Dvld,
   input  logic [127:0] Dout
);

   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE,
      KEY_LOAD,
      KEY_WAIT,
      DATA_LOAD,
      DATA_WAIT,
      RESP
   } state_t;

   state_t          state;
   state_t          state_nxt;

   logic [127:0]    key_q;
   logic [127:0]    din_q;
   logic            mode_q;
   logic            owner;
   logic            rr_last;
   logic            cache_vld;
   logic [127:0]    cache_key;
   logic [CW-1:0]   wd_cnt;

   logic            gsel;
   logic            grant;
   logic            hit;
   logic            wd_expire;
   logic            abort;
   logic [127:0]    sel_key;
   logic [127:0]    sel_din;

   // rr_last holds the last winner; on contention the other requester wins
   always_comb begin
      gsel      = (&rq_vld) ? ~rr_last : ~rq_vld[0];
      sel_key   = gsel ? rq_key1 : rq_key0;
      sel_din   = gsel ? rq_din1 : rq_din0;
      grant     = (state == IDLE) && enable && (|rq_vld) && !BSY;
      hit       = cache_vld && !key_flush && (cache_key == sel_key);
      wd_expire = (wd_cnt == CW'(TIMEOUT - 1));
      abort     = wd_expire && (((state == KEY_WAIT) && !Kvld) ||
                                ((state == DATA_WAIT) && !Dvld));
   end

   always_comb begin
      state_nxt = state;
      Krdy      = 1'b0;
      Drdy      = 1'b0;
      case (state)
         IDLE: begin
            if (grant) begin
               state_nxt = hit ? DATA_LOAD : KEY_LOAD;
            end
         end
         KEY_LOAD: begin
            Krdy      = 1'b1;
            state_nxt = KEY_WAIT;
         end
         KEY_WAIT: begin
            if (Kvld) begin
               state_nxt = DATA_LOAD;
            end else if (wd_expire) begin
               state_nxt = IDLE;
            end
         end
         DATA_LOAD: begin
            Drdy      = 1'b1;
            state_nxt = DATA_WAIT;
         end
         DATA_WAIT: begin
            if (Dvld) begin
               state_nxt = RESP;
            end else if (wd_expire) begin
               state_nxt = IDLE;
            end
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         key_q     <= '0;
         din_q     <= '0;
         mode_q    <= 1'b0;
         owner     <= 1'b0;
         rr_last   <= 1'b1;
         cache_vld <= 1'b0;
         cache_key <= '0;
         wd_cnt    <= '0;
         rq_ack    <= '0;
         rsp_vld   <= '0;
         rsp_err   <= 1'b0;
         rsp_data  <= '0;
      end else begin
         rq_ack  <= '0;
         rsp_vld <= '0;
         rsp_err <= 1'b0;

         if (grant) begin
            key_q   <= sel_key;
            din_q   <= sel_din;
            mode_q  <= rq_encdec[gsel];
            owner   <= gsel;
            rr_last <= gsel;
            rq_ack  <= gsel ? 2'b10 : 2'b01;
         end

         // load states precede every wait state, so clearing here gives count 0 on entry
         if ((state == KEY_WAIT) || (state == DATA_WAIT)) begin
            wd_cnt <= wd_cnt + CW'(1);
         end else begin
            wd_cnt <= '0;
         end

         // a flush coincident with Kvld leaves the cache invalid
         if (key_flush || abort) begin
            cache_vld <= 1'b0;
         end else if ((state == KEY_WAIT) && Kvld) begin
            cache_vld <= 1'b1;
            cache_key <= key_q;
         end

         if ((state == DATA_WAIT) && Dvld) begin
            rsp_data <= Dout;
         end

         if ((state == RESP) || abort) begin
            rsp_vld <= owner ? 2'b10 : 2'b01;
            rsp_err <= abort;
         end
      end
   end

   assign Kin    = key_q;
   assign Din    = din_q;
   assign EncDec = mode_q;

endmodule

// File: tb/tb_aes_core_sched.sv
// Directed bench for aes_core_sched with a behavioural AES core responder.
module tb_aes_core_sched;

   localparam int KD = 10;
   localparam int DD = 11;
   localparam logic [127:0] K0   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] D0   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] D1   = 128'hffeeddccbbaa99887766554433221100;
   localparam logic [127:0] D2   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] D3   = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] AES0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk;
   logic         RST;
   logic         enable;
   logic         key_flush;
   logic [1:0]   rq_vld;
   logic [127:0] rq_key0, rq_key1, rq_din0, rq_din1;
   logic [1:0]   rq_encdec;
   logic [1:0]   rq_ack;
   logic [1:0]   rsp_vld;
   logic [127:0] rsp_data;
   logic         rsp_err;
   logic [127:0] Kin, Din;
   logic         Krdy, Drdy, EncDec;
   logic         BSY, Kvld, Dvld;
   logic [127:0] Dout;

   int n_tot = 0;
   int n_bad = 0;
   int cyc = 0;

   bit           hang = 0;
   int           kdue = -1;
   int           ddue = -1;
   logic [127:0] ckey = '0;
   logic [127:0] dres = '0;
   int           nkrdy = 0, ndrdy = 0, krdy_cyc = -1, drdy_cyc = -1;

   logic [1:0]   a_v, r_v;
   logic         r_e;
   logic [127:0] r_d;
   int           a_c, r_c, nk0, nd0, e_c, got;
   logic [1:0]   ack_q[$];
   logic [1:0]   rsp_q[$];
   logic         rspe_q[$];
   logic [127:0] rspd_q[$];

   aes_core_sched #(.TIMEOUT(16)) dut (
      .clk(clk), .RST(RST), .enable(enable), .key_flush(key_flush),
      .rq_vld(rq_vld), .rq_key0(rq_key0), .rq_key1(rq_key1),
      .rq_din0(rq_din0), .rq_din1(rq_din1), .rq_encdec(rq_encdec),
      .rq_ack(rq_ack), .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .Kin(Kin), .Din(Din), .Krdy(Krdy), .Drdy(Drdy), .EncDec(EncDec),
      .BSY(BSY), .Kvld(Kvld), .Dvld(Dvld), .Dout(Dout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc = cyc + 1;

   function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] d, input logic m);
      if (k == K0 && d == D0 && !m) return AES0;
      return d ^ k ^ {128{m}};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
      n_tot++;
      assert (obs === exp_v) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp_v);
      n_tot++;
      assert (obs == exp_v) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   // Core responder plus per-cycle protocol checks
   always @(negedge clk) begin
      if (RST) begin
         kdue = -1;
         ddue = -1;
         Kvld = 1'b0;
         Dvld = 1'b0;
      end else begin
         Kvld = (cyc == kdue);
         Dvld = (cyc == ddue) && !hang;
         Dout = Dvld ? dres : ~dres;
         if (Krdy) begin
            kdue = cyc + KD; ckey = Kin; nkrdy++; krdy_cyc = cyc;
         end
         if (Drdy) begin
            ddue = cyc + DD; dres = core_fn(ckey, Din, EncDec); ndrdy++; drdy_cyc = cyc;
         end
         if (rq_ack != 2'b00) chki("ack_onehot", int'($onehot(rq_ack)), 1);
         if (rsp_vld != 2'b00) chki("rsp_onehot", int'($onehot(rsp_vld)), 1);
         if (Krdy || Drdy) chki("krdy_drdy_excl", int'(Krdy & Drdy), 0);
      end
   end

   task automatic run_job(input logic [1:0] who, input logic [127:0] k, input logic [127:0] d,
                          input logic m, output logic [1:0] av, output int ac,
                          output logic [1:0] rv, output logic re, output logic [127:0] rd,
                          output int rc);
      av = '0; rv = '0; re = 1'b0; rd = '0; ac = -1; rc = -1;
      if (who[1]) begin
         rq_key1 = k; rq_din1 = d; rq_encdec[1] = m;
      end else begin
         rq_key0 = k; rq_din0 = d; rq_encdec[0] = m;
      end
      rq_vld = who;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rq_ack != 2'b00) begin av = rq_ack; ac = cyc; break; end
      end
      rq_vld = 2'b00;
      chki("ack_seen", int'(ac >= 0), 1);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (rsp_vld != 2'b00) begin rv = rsp_vld; re = rsp_err; rd = rsp_data; rc = cyc; break; end
      end
      chki("rsp_seen", int'(rc >= 0), 1);
   endtask

   task automatic check_reset(input string p);
      chk({p, "_rq_ack"}, 128'(rq_ack), '0);
      chk({p, "_rsp_vld"}, 128'(rsp_vld), '0);
      chk({p, "_rsp_err"}, 128'(rsp_err), '0);
      chk({p, "_rsp_data"}, rsp_data, '0);
      chk({p, "_Kin"}, Kin, '0);
      chk({p, "_Din"}, Din, '0);
      chk({p, "_Krdy"}, 128'(Krdy), '0);
      chk({p, "_Drdy"}, 128'(Drdy), '0);
      chk({p, "_EncDec"}, 128'(EncDec), '0);
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      RST = 1'b1; enable = 1'b1; key_flush = 1'b0; rq_vld = 2'b00; BSY = 1'b0;
      rq_key0 = '0; rq_key1 = '0; rq_din0 = '0; rq_din1 = '0; rq_encdec = 2'b00;
      Kvld = 1'b0; Dvld = 1'b0; Dout = '0;
      repeat (3) @(negedge clk);
      check_reset("reset");
      RST = 1'b0;
      @(negedge clk);

      // Single miss with the FIPS-197 vector
      nk0 = nkrdy; nd0 = ndrdy;
      run_job(2'b01, K0, D0, 1'b0, a_v, a_c, r_v, r_e, r_d, r_c);
      chk("miss_ack", 128'(a_v), 128'(2'b01));
      chki("miss_krdy_cnt", nkrdy - nk0, 1);
      chki("miss_drdy_cnt", ndrdy - nd0, 1);
      chki("miss_krdy_cycle", krdy_cyc, a_c);
      chki("miss_drdy_cycle", drdy_cyc, krdy_cyc + KD + 1);
      chki("miss_rsp_cycle", r_c, drdy_cyc + DD + 2);
      chk("miss_rsp_vld", 128'(r_v), 128'(2'b01));
      chk("miss_rsp_err", 128'(r_e), '0);
      chk("miss_rsp_data", r_d, AES0);

      // Cache hit: same key, new data
      nk0 = nkrdy;
      run_job(2'b01, K0, D1, 1'b0, a_v, a_c, r_v, r_e, r_d, r_c);
      chki("hit_no_krdy", nkrdy - nk0, 0);
      chki("hit_drdy_cycle", drdy_cyc, a_c);
      chki("hit_rsp_cycle", r_c, a_c + DD + 2);
      chk("hit_rsp_data", r_d, D1 ^ K0);

      // Flush forces a reload
      key_flush = 1'b1;
      @(negedge clk);
      key_flush = 1'b0;
      nk0 = nkrdy;
      run_job(2'b01, K0, D1, 1'b0, a_v, a_c, r_v, r_e, r_d, r_c);
      chki("flush_krdy", nkrdy - nk0, 1);
      chk("flush_rsp_data", r_d, D1 ^ K0);

      // Watchdog: core never answers Dvld
      hang = 1'b1;
      run_job(2'b01, K0, D0, 1'b0, a_v, a_c, r_v, r_e, r_d, r_c);
      chk("wd_rsp_vld", 128'(r_v), 128'(2'b01));
      chk("wd_rsp_err", 128'(r_e), 128'(1'b1));
      chk("wd_rsp_data_held", r_d, D1 ^ K0);
      chki("wd_latency", r_c - (drdy_cyc + 1), 16);
      hang = 1'b0;
      nk0 = nkrdy;
      run_job(2'b01, K0, D0, 1'b0, a_v, a_c, r_v, r_e, r_d, r_c);
      chki("wd_reload_krdy", nkrdy - nk0, 1);
      chk("wd_next_err", 128'(r_e), '0);
      chk("wd_next_data", r_d, AES0);

      // Reset while in KEY_WAIT (K1 misses the cached K0)
      rq_key0 = K1; rq_din0 = D0; rq_encdec[0] = 1'b0; rq_vld = 2'b01;
      got = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rq_ack != 2'b00) begin got = 1; break; end
      end
      rq_vld = 2'b00;
      chki("rstmid_ack_seen", got, 1);
      repeat (3) @(negedge clk);
      chki("rstmid_in_key_wait", int'(Kin == K1 && !Krdy), 1);
      RST = 1'b1;
      @(negedge clk);
      check_reset("rstmid");
      RST = 1'b0;

      // Arbitration: both request continuously for six jobs
      rq_key0 = K0; rq_din0 = D0; rq_key1 = K1; rq_din1 = D2; rq_encdec = 2'b10;
      nk0 = nkrdy;
      rq_vld = 2'b11;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (rq_ack != 2'b00) begin
            ack_q.push_back(rq_ack);
            if (ack_q.size() == 6) rq_vld = 2'b00;
         end
         if (rsp_vld != 2'b00) begin
            rsp_q.push_back(rsp_vld); rspe_q.push_back(rsp_err); rspd_q.push_back(rsp_data);
         end
         if (rsp_q.size() == 6) break;
      end
      rq_vld = 2'b00;
      chki("arb_ack_count", ack_q.size(), 6);
      chki("arb_rsp_count", rsp_q.size(), 6);
      chki("arb_krdy_count", nkrdy - nk0, 6);
      for (int i = 0; i < 6; i++) begin
         if (i < ack_q.size())
            chk($sformatf("arb_ack_%0d", i), 128'(ack_q[i]), (i % 2 == 1) ? 128'(2'b10) : 128'(2'b01));
         if (i < rsp_q.size()) begin
            chk($sformatf("arb_rsp_%0d", i), 128'(rsp_q[i]), (i % 2 == 1) ? 128'(2'b10) : 128'(2'b01));
            chk($sformatf("arb_err_%0d", i), 128'(rspe_q[i]), '0);
            chk($sformatf("arb_data_%0d", i), rspd_q[i], (i % 2 == 1) ? (D2 ^ K1 ^ {128{1'b1}}) : AES0);
         end
      end

      // enable gating: no grant while low, grant the cycle after it rises
      enable = 1'b0;
      rq_key1 = K1; rq_din1 = D3; rq_encdec[1] = 1'b0; rq_vld = 2'b10;
      got = 0;
      repeat (5) begin
         @(negedge clk);
         if (rq_ack != 2'b00) got++;
      end
      chki("en_low_no_ack", got, 0);
      enable = 1'b1;
      e_c = cyc;
      @(negedge clk);
      chk("en_rise_ack", 128'(rq_ack), 128'(2'b10));
      chki("en_rise_cycle", cyc, e_c + 1);
      rq_vld = 2'b00;
      for (int i = 0; i < 40; i++) begin
         if (Drdy) break;
         @(negedge clk);
      end
      repeat (2) @(negedge clk);
      enable = 1'b0;
      r_c = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (rsp_vld != 2'b00) begin r_v = rsp_vld; r_e = rsp_err; r_d = rsp_data; r_c = cyc; break; end
      end
      chki("en_drop_rsp_seen", int'(r_c >= 0), 1);
      chk("en_drop_rsp_vld", 128'(r_v), 128'(2'b10));
      chk("en_drop_rsp_err", 128'(r_e), '0);
      chk("en_drop_rsp_data", r_d, D3 ^ K1);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
